// File: rtl/display_scanner.sv
// Multiplexed BCD display scanner with double-buffered frame store and guarded digit slots.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is never blanked).
module display_scanner #(
  parameter int DIGITS       = 4,
  parameter int SLOT_CYCLES  = 1000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  blank,
  output logic                  frame_start
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [0:0]          state_q, state_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                full_q, full_d;

  logic                wr_ready_q, wr_ready_d;
  logic [3:0]          bcd_q, bcd_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                blank_q, blank_d;
  logic                frame_start_q, frame_start_d;

  logic                cnt_wrap_s;
  logic                frame_end_s;
  logic                accept_s;
  logic [3:0]          nib_s;

  // True when digit idx and every more significant digit of the frame are zero.
  function automatic logic leading_zero(input logic [4*DIGITS-1:0] frame, input logic [IW-1:0] idx);
    logic [4*DIGITS-1:0] upper;
    upper = frame >> (4 * idx);
    return (idx != '0) && (upper == '0);
  endfunction

  // Scan timing, FSM and frame-store next state.
  always_comb begin
    cnt_wrap_s  = (cnt_q == CNT_LAST);
    frame_end_s = cnt_wrap_s && (idx_q == IDX_LAST);
    accept_s    = wr_valid && wr_ready_q;

    cnt_d = cnt_wrap_s ? '0 : cnt_q + 1'b1;
    if (cnt_wrap_s) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      idx_d = idx_q;
    end

    case (state_q)
      ST_GUARD: state_d = (cnt_d >= GUARD_END) ? ST_ON : ST_GUARD;
      ST_ON:    state_d = cnt_wrap_s ? ST_GUARD : ST_ON;
      default:  state_d = ST_GUARD;
    endcase

    active_d = active_q;
    shadow_d = shadow_q;
    full_d   = full_q;
    // Swap only at the frame boundary so a displayed frame never tears.
    if (frame_end_s && full_q) begin
      active_d = shadow_q;
      full_d   = 1'b0;
    end else begin
      full_d   = full_q;
    end
    if (accept_s) begin
      shadow_d = wr_data;
      full_d   = 1'b1;
    end else begin
      shadow_d = shadow_d;
    end
  end

  // Output register inputs, derived from the current registered state.
  always_comb begin
    nib_s         = active_q[4*idx_q +: 4];
    bcd_d         = nib_s;
    digit_en_d    = (state_q == ST_ON) ? ({{(DIGITS-1){1'b0}}, 1'b1} << idx_q) : '0;
    frame_start_d = (cnt_q == '0) && (idx_q == '0);
    wr_ready_d    = !full_d;
`ifdef LEADING_ZERO_BLANK_EN
    blank_d       = (nib_s > 4'd9) || leading_zero(active_q, idx_q);
`else
    blank_d       = (nib_s > 4'd9);
`endif
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      state_q       <= ST_GUARD;
      active_q      <= '0;
      shadow_q      <= '0;
      full_q        <= 1'b0;
      wr_ready_q    <= 1'b1;
      bcd_q         <= 4'd0;
      digit_en_q    <= '0;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      state_q       <= state_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      full_q        <= full_d;
      wr_ready_q    <= wr_ready_d;
      bcd_q         <= bcd_d;
      digit_en_q    <= digit_en_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign bcd         = bcd_q;
  assign digit_en    = digit_en_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits; legal range 2..8.
REQ-002 Parameter SLOT_CYCLES, default 1000: clock cycles per digit time slot; legal range 4..65535.
REQ-003 Parameter GUARD_CYCLES, default 2: dark cycles at the start of each slot; legal range 1..SLOT_CYCLES-2.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port wr_data, input, 4*DIGITS: BCD frame; nibble i = wr_data[4i+3:4i]; digit 0 is least significant (rightmost).
REQ-007 Port wr_valid, input, 1: wr_data is valid this cycle.
REQ-008 Port wr_ready, output, 1: shadow register is empty and can accept a frame.
REQ-009 Port bcd, output, 4: BCD nibble of the current digit, driven as x3..x0 into the downstream seven-segment decoder.
REQ-010 Port digit_en, output, DIGITS: one-hot, active-high digit common enable.
REQ-011 Port blank, output, 1: high means the downstream segments are forced off for the current slot.
REQ-012 Port frame_start, output, 1: one-cycle pulse at the first cycle of digit 0's slot.

Function
REQ-013 The block SHALL hold two frame stores: a shadow register with a full flag, and an active register that is displayed.
REQ-014 wr_ready SHALL equal NOT shadow_full; the block SHALL accept a frame on a rising edge where wr_valid and wr_ready are both high, then store it in the shadow register and set shadow_full.
REQ-015 When wr_ready is low, the block SHALL ignore wr_valid and wr_data, and the producer SHALL hold both until acceptance.
REQ-016 Slot counter cnt SHALL count 0..SLOT_CYCLES-1 and then wrap to 0.
REQ-017 On each cnt wrap, digit index idx SHALL increment, wrapping from DIGITS-1 to 0.
REQ-018 The scan SHALL be a two-state FSM, GUARD then ON:
- GUARD while cnt < GUARD_CYCLES.
- ON while GUARD_CYCLES <= cnt <= SLOT_CYCLES-1.
- The FSM SHALL return to GUARD on each cnt wrap.
REQ-019 In GUARD, digit_en SHALL be all zeros; in ON, digit_en SHALL be one-hot at bit idx.
REQ-020 bcd SHALL equal active nibble idx for the whole slot.
REQ-021 A frame boundary is the edge where cnt = SLOT_CYCLES-1 and idx = DIGITS-1; if shadow_full is set at that edge, the block SHALL copy shadow to active and clear shadow_full.
REQ-022 A frame accepted on the frame-boundary edge itself SHALL go to the shadow register only and SHALL be displayed from the following frame boundary; the display SHALL never tear within a frame.
REQ-023 blank SHALL be high for any slot whose nibble exceeds 9; bcd SHALL still show the raw nibble in that slot.
REQ-024 frame_start SHALL be high exactly when idx = 0 and cnt = 0.
REQ-025 All outputs SHALL be registered, and every output SHALL be a function of the registered state.
REQ-026 No handshake or frame input SHALL stall or reset the scan timing.

Reset
REQ-027 While rst is high, the block SHALL hold cnt = 0, idx = 0, state GUARD, active = 0, shadow = 0, shadow_full = 0.
REQ-028 While rst is high, the outputs SHALL be: digit_en = 0, bcd = 0, blank = 1, frame_start = 0, wr_ready = 1.
REQ-029 On the first rising edge after rst deasserts, the scan SHALL start with frame_start = 1 and digit 0 in GUARD.
REQ-030 A reset asserted mid-slot or mid-handshake SHALL discard any pending shadow frame and turn all digits off immediately (asynchronous).

Configuration
REQ-031 Macro LEADING_ZERO_BLANK_EN SHALL select the leading-zero behaviour:
- Defined: blank SHALL also be high for digit i (i > 0) when active nibbles i..DIGITS-1 are all zero; digit 0 SHALL never be blanked for being zero.
- Undefined: zero digits SHALL display normally, and blank SHALL depend only on REQ-023.

Verification (DIGITS=4, SLOT_CYCLES=8, GUARD_CYCLES=2)
REQ-032 Reset scan: release rst, no writes -> frame_start pulses every 32 cycles, and digit_en follows the sequence 0000 x2, 0001 x6, 0000 x2, 0010 x6, ... with bcd = 0 throughout.
REQ-033 Write and latency: accept 16'h1234 mid-frame -> display unchanged until the boundary, then bcd = 4,3,2,1 for digits 0..3 in the next frame.
REQ-034 Backpressure: write 16'h1111 then attempt 16'h2222 before the boundary -> wr_ready = 0 and 16'h2222 is ignored until the boundary; 16'h1111 is displayed and 16'h2222 is accepted after.
REQ-035 Boundary-edge write: accept 16'h5678 exactly on the frame-boundary edge -> the current frame repeats once, and 16'h5678 is displayed one frame later.
REQ-036 Invalid BCD: frame 16'h00A7 -> digit 1 shows bcd = A with blank = 1.
- With LEADING_ZERO_BLANK_EN defined: digits 2 and 3 blank = 1.
- Without it: digits 2 and 3 blank = 0 with bcd = 0.
REQ-037 Async reset mid-ON slot of digit 2 with a shadow frame pending -> digit_en goes to 0 in the same cycle, wr_ready = 1, and the pending frame is never displayed.
